knn_vote_merge: RTL and testbench

//  Downstream stage of the update_knn partial-search operators in the digit recognition page flow.

---
 rtl/knn_vote_merge.sv | 167 ++++++++++++++++
 tb/tb_knn_vote_merge.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/knn_vote_merge.sv
// knn_vote_merge: final stage after the update_knn partial-search operators.
// Keeps the K nearest (distance, label) candidates of each test digit in a
// sorted list, votes on their labels and hands one predicted label downstream.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   in_data/in_vld/in_ack candidate word in: label=[19:16], distance=[DIST_BITS-1:0]
//   out_data/out_vld/out_ack  result out: {28'b0, predicted_label}
//   busy                  high unless idle in COLLECT with no words taken
//   items_done            results delivered since reset (wraps)
module knn_vote_merge #(
    parameter int K         = 3,
    parameter int NUM_CANDS = 15,
    parameter int DIST_BITS = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] in_data,
    input  logic        in_vld,
    output logic        in_ack,
    output logic [31:0] out_data,
    input  logic        out_ack,
    output logic        out_vld,
    output logic        busy,
    output logic [15:0] items_done
);
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);
    localparam logic [7:0]    LAST_CNT = 8'(NUM_CANDS - 1);

    typedef enum logic [1:0] {COLLECT, HIST, ARGMAX, EMIT} state_t;
    state_t state, state_nxt;

    logic [K-1:0][DIST_BITS-1:0] dist_q, dist_nxt;
    logic [K-1:0][3:0]           lab_q, lab_nxt;
    logic [K-1:0]                full_q, full_nxt;
    logic [7:0]                  count;
    logic [IW-1:0]               idx;
    logic [15:0][3:0]            hist;
    logic [3:0]                  best_label, best_count;
    logic                        ack_q;
    logic                        accept;
    logic [DIST_BITS-1:0]        new_dist;
    logic [3:0]                  new_lab, cur_lab;
    logic                        upd;
    logic                        unused_in;

    assign new_dist  = in_data[DIST_BITS-1:0];
    assign new_lab   = in_data[19:16];
    assign unused_in = ^in_data;
    assign in_ack    = ack_q;
    assign accept    = in_vld && ack_q && (state == COLLECT);
    assign out_vld   = (state == EMIT);
    assign busy      = !((state == COLLECT) && (count == 8'd0));
    assign cur_lab   = lab_q[idx];
    assign upd       = hist[cur_lab] > best_count;

    // Sorted insert. An empty slot counts as "greater", so the first
    // words always land even at the all-ones distance. Because valid entries
    // form a prefix and distances ascend, the greater-than vector is
    // monotonic: ranks at/after the insert point take their predecessor,
    // the insert point itself takes the new word.
    always_comb begin
        logic                 pg, pf, g;
        logic [DIST_BITS-1:0] pd;
        logic [3:0]           pl;
        pg = 1'b0; pf = 1'b0; pd = '0; pl = '0;
        dist_nxt = dist_q;
        lab_nxt  = lab_q;
        full_nxt = full_q;
        for (int r = 0; r < K; r++) begin
            g = !full_q[r] || (dist_q[r] > new_dist);
            if (g && pg) begin
                dist_nxt[r] = pd; lab_nxt[r] = pl; full_nxt[r] = pf;
            end else if (g) begin
                dist_nxt[r] = new_dist; lab_nxt[r] = new_lab; full_nxt[r] = 1'b1;
            end
            pg = g; pd = dist_q[r]; pl = lab_q[r]; pf = full_q[r];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (accept && count == LAST_CNT) state_nxt = HIST;
            HIST:    if (idx == LAST_IDX) state_nxt = ARGMAX;
            ARGMAX:  if (idx == LAST_IDX) state_nxt = EMIT;
            EMIT:    if (out_ack) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dist_q     <= '1;
            lab_q      <= '0;
            full_q     <= '0;
            count      <= '0;
            idx        <= '0;
            hist       <= '0;
            best_label <= '0;
            best_count <= '0;
            out_data   <= '0;
            items_done <= '0;
            ack_q      <= 1'b0;
        end else begin
            // Registered so in_ack stays low through reset and never
            // depends combinationally on in_vld.
            ack_q <= (state_nxt == COLLECT);
            case (state)
                COLLECT: begin
                    if (accept) begin
                        dist_q <= dist_nxt;
                        lab_q  <= lab_nxt;
                        full_q <= full_nxt;
                        count  <= count + 8'd1;
                        if (count == LAST_CNT) begin
                            hist <= '0;
                            idx  <= '0;
                        end
                    end
                end
                HIST: begin
                    hist[cur_lab] <= hist[cur_lab] + 4'd1;
                    if (idx == LAST_IDX) begin
                        idx        <= '0;
                        best_count <= '0;
                        best_label <= '0;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                ARGMAX: begin
                    if (upd) begin
                        best_count <= hist[cur_lab];
                        best_label <= cur_lab;
                    end
                    if (idx == LAST_IDX) begin
                        idx      <= '0;
                        out_data <= {28'b0, (upd ? cur_lab : best_label)};
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                EMIT: begin
                    if (out_ack) begin
                        items_done <= items_done + 16'd1;
                        dist_q     <= '1;
                        lab_q      <= '0;
                        full_q     <= '0;
                        count      <= '0;
                        hist       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_knn_vote_merge.sv
module tb_knn_vote_merge;
    localparam int K  = 3;
    localparam int NC = 5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] in_data;
    logic        in_vld;
    logic        in_ack;
    logic [31:0] out_data;
    logic        out_ack;
    logic        out_vld;
    logic        busy;
    logic [15:0] items_done;

    knn_vote_merge #(.K(K), .NUM_CANDS(NC), .DIST_BITS(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_vld(in_vld), .in_ack(in_ack),
        .out_data(out_data), .out_ack(out_ack), .out_vld(out_vld),
        .busy(busy), .items_done(items_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_acc = 0;
    int exp_done = 0;
    int ack_mode = 0;   // 0: always ack, 1: random, 2: hold low
    logic prev_vld = 1'b0;
    logic [3:0] exp_q[$];
    logic [15:0] da [NC];
    logic [3:0]  la [NC];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ack_mode)
            0: out_ack = 1'b1;
            1: out_ack = ($urandom_range(0, 2) != 0);
            default: out_ack = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: stable K-smallest selection, then count votes among them;
    // the first rank reaching a strictly higher count wins.
    function automatic logic [3:0] ref_vote(input logic [15:0] d[NC], input logic [3:0] l[NC]);
        bit         used[NC];
        logic [3:0] top[K];
        int         b, c, bestc;
        logic [3:0] res;
        for (int i = 0; i < NC; i++) used[i] = 1'b0;
        for (int k = 0; k < K; k++) begin
            b = -1;
            for (int i = 0; i < NC; i++)
                if (!used[i] && (b < 0 || d[i] < d[b])) b = i;
            used[b] = 1'b1;
            top[k] = l[b];
        end
        bestc = 0; res = 4'd0;
        for (int r = 0; r < K; r++) begin
            c = 0;
            for (int s = 0; s < K; s++) if (top[s] == top[r]) c++;
            if (c > bestc) begin bestc = c; res = top[r]; end
        end
        return res;
    endfunction

    task automatic send_word(input logic [15:0] d, input logic [3:0] l, input bit gaps);
        bit acc;
        int n;
        in_data = {12'($urandom), l, d};
        in_vld  = 1'b1;
        acc = 1'b0; n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ack;
            n++;
        end
        if (!acc) chk("accept_timeout", {31'b0, in_ack}, 32'd1);
        last_acc = cyc;
        @(posedge clk); #1;
        in_vld = 1'b0;
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    endtask

    task automatic send_item(input bit gaps);
        for (int i = 0; i < NC; i++) send_word(da[i], la[i], gaps);
        exp_q.push_back(ref_vote(da, la));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 1000) begin @(negedge clk); n++; end
        if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic rand_item();
        for (int i = 0; i < NC; i++) begin
            da[i] = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 15));
            la[i] = 4'($urandom_range(0, 15));
        end
    endtask

    // Monitor: compares every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (reset_n) begin
            if (out_vld) begin
                if (!prev_vld) chk("latency", cyc - last_acc, 7);
                chk("in_ack_in_emit", {31'b0, in_ack}, 0);
                chk("items_done", {16'b0, items_done}, exp_done);
                if (exp_q.size() == 0) chk("unexpected_out", {31'b0, out_vld}, 0);
                else begin
                    chk("result", out_data, {28'b0, exp_q[0]});
                    if (out_ack) begin
                        void'(exp_q.pop_front());
                        exp_done++;
                    end
                end
            end
            prev_vld = out_vld;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n;
        reset_n = 1'b0; in_vld = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ack", {31'b0, in_ack}, 0);
        chk("rst_out_vld", {31'b0, out_vld}, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_items_done", {16'b0, items_done}, 0);
        @(posedge clk); #1; reset_n = 1'b1;

        // Nearest three: (5,7),(5,2),(8,7) -> 7
        da = '{16'd10, 16'd5, 16'd20, 16'd5, 16'd8};
        la = '{4'd3, 4'd7, 4'd1, 4'd2, 4'd7};
        send_item(1'b0); drain();
        chk("out_data_held", out_data, 32'd7);

        // All counts one among the nearest three: closest wins -> 2
        da = '{16'd4, 16'd6, 16'd9, 16'd20, 16'd30};
        la = '{4'd2, 4'd5, 4'd9, 4'd1, 4'd1};
        send_item(1'b0); drain();

        // Equal distances keep arrival order: (7,4),(7,6),(7,6) -> 6
        da = '{16'd7, 16'd7, 16'd7, 16'd7, 16'd9};
        la = '{4'd4, 4'd6, 4'd6, 4'd1, 4'd1};
        send_item(1'b1); drain();

        // Backpressure: result must stay put while out_ack is low
        ack_mode = 2;
        rand_item(); send_item(1'b0);
        n = 0;
        while (!out_vld && n < 50) begin @(negedge clk); n++; end
        repeat (5) begin
            @(negedge clk);
            chk("hold_vld", {31'b0, out_vld}, 1);
            chk("hold_no_ack", {31'b0, in_ack}, 0);
        end
        base = exp_done;
        ack_mode = 0;
        drain();
        chk("one_accept", {16'b0, items_done}, base + 1);

        // Reset mid-item discards the partial words
        send_word(16'd3, 4'd5, 1'b0);
        send_word(16'd1, 4'd5, 1'b0);
        @(negedge clk);
        chk("busy_mid", {31'b0, busy}, 1);
        @(posedge clk); #1; reset_n = 1'b0; exp_done = 0;
        repeat (2) begin
            @(negedge clk);
            chk("mid_rst_in_ack", {31'b0, in_ack}, 0);
            chk("mid_rst_out_vld", {31'b0, out_vld}, 0);
        end
        @(posedge clk); #1; reset_n = 1'b1;
        da = '{16'd9, 16'd2, 16'd4, 16'd2, 16'd50};
        la = '{4'd1, 4'd12, 4'd3, 4'd3, 4'd12};
        send_item(1'b0); drain();
        chk("done_after_reset", {16'b0, items_done}, 1);

        // Two back-to-back items with gaps on in_vld
        base = items_done;
        rand_item(); send_item(1'b1);
        rand_item(); send_item(1'b1);
        drain();
        chk("two_items", {16'b0, items_done}, base + 2);

        // Randomized items with random out_ack
        ack_mode = 1;
        for (int t = 0; t < 30; t++) begin
            rand_item(); send_item(1'b1);
        end
        drain();
        ack_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("final_done", {16'b0, items_done}, exp_done);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
